// File: rtl/dnn_sample_feeder.sv
// dnn_sample_feeder: ping-pong sample buffer feeding act0/ans0/etapos0 into the
// DNN top one chunk per clock, locked to the shared block-cycle counter.
module dnn_sample_feeder #(
  parameter int width_in = 8,
  parameter int p        = 1024,
  parameter int zbyfo    = 16,
  parameter int nout     = 64,
  parameter int answ     = 1,
  parameter int ec       = 2,
  parameter int etaw     = 4,
  localparam int chunks  = p / zbyfo,
  localparam int cpc     = chunks + ec,
  localparam int achunks = nout / answ,
  localparam int CW      = $clog2(cpc)
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [CW-1:0]                  cycle_index,
  input  logic                           ld_valid,
  output logic                           ld_ready,
  input  logic [zbyfo-1:0][width_in-1:0] ld_act,
  input  logic [nout-1:0]                ld_ans,
  input  logic [etaw-1:0]                ld_etapos,
  output logic [zbyfo-1:0][width_in-1:0] act0,
  output logic [answ-1:0]                ans0,
  output logic [etaw-1:0]                etapos0,
  output logic                           sample_valid,
  output logic [15:0]                    fed_count,
  output logic [15:0]                    underflow_count
);

  localparam int PW = (chunks > 1) ? $clog2(chunks) : 1;
  localparam int AW = (achunks > 1) ? $clog2(achunks) : 1;

  localparam logic [CW-1:0] LAST_C   = CW'(cpc - 1);
  localparam logic [CW-1:0] CHUNKS_C = CW'(chunks);
  localparam logic [CW-1:0] ACH_C    = CW'(achunks);
  localparam logic [PW-1:0] PTR_LAST = PW'(chunks - 1);

  if (p % zbyfo != 0 || nout % answ != 0 || achunks > chunks) begin : g_param_check
    $error("dnn_sample_feeder: p%%zbyfo, nout%%answ must be 0 and nout/answ <= p/zbyfo");
  end

  // two sample banks
  logic [zbyfo-1:0][width_in-1:0] mem     [2][chunks];
  logic [achunks-1:0][answ-1:0]   ans_mem [2];
  logic [etaw-1:0]                eta_mem [2];
  logic [1:0]                     full;

  logic          wr_bank, rd_bank, playing;
  logic [PW-1:0] ptr;

  logic          fire, nb;
  logic [CW-1:0] nxt;
  logic [PW-1:0] cidx;
  logic [AW-1:0] aidx;

  assign ld_ready     = !full[wr_bank];
  assign fire         = ld_valid && ld_ready;
  // after a release the just-emptied bank is skipped; otherwise retry the same bank
  assign nb           = playing ? ~rd_bank : rd_bank;
  assign nxt          = cycle_index + 1'b1;
  assign cidx         = nxt[PW-1:0];
  assign aidx         = nxt[AW-1:0];
  assign sample_valid = playing;

  // bank payload write; no reset needed since the full flags gate every read
  always_ff @(posedge clk) begin
    if (!reset && fire) begin
      mem[wr_bank][ptr] <= ld_act;
      if (ptr == PTR_LAST) begin
        ans_mem[wr_bank] <= ld_ans;
        eta_mem[wr_bank] <= ld_etapos;
      end
    end
  end

  // load bookkeeping, boundary bank selection and registered stream outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      full            <= '0;
      wr_bank         <= 1'b0;
      rd_bank         <= 1'b0;
      playing         <= 1'b0;
      ptr             <= '0;
      act0            <= '0;
      ans0            <= '0;
      etapos0         <= '0;
      fed_count       <= '0;
      underflow_count <= '0;
    end else begin
      if (fire) begin
        if (ptr == PTR_LAST) begin
          full[wr_bank] <= 1'b1;
          wr_bank       <= ~wr_bank;
          ptr           <= '0;
        end else begin
          ptr <= ptr + 1'b1;
        end
      end

      if (cycle_index == LAST_C) begin
        // a bank completing on this same edge is not seen: full[] is the pre-edge value
        if (playing) full[rd_bank] <= 1'b0;
        // the read pointer follows write order even through a bubble, so the
        // next bank the loader fills is the one looked at next boundary
        rd_bank <= nb;
        if (full[nb]) begin
          playing   <= 1'b1;
          fed_count <= fed_count + 16'd1;
          act0      <= mem[nb][0];
          ans0      <= ans_mem[nb][0];
          etapos0   <= eta_mem[nb];
        end else begin
          playing         <= 1'b0;
          underflow_count <= underflow_count + 16'd1;
          act0            <= '0;
          ans0            <= '0;
          etapos0         <= '0;
        end
      end else if (playing && nxt < CHUNKS_C) begin
        act0 <= mem[rd_bank][cidx];
        ans0 <= (nxt < ACH_C) ? ans_mem[rd_bank][aidx] : '0;
      end else begin
        act0 <= '0;
        ans0 <= '0;
      end
    end
  end

endmodule

// File: tb/tb_dnn_sample_feeder.sv
// Directed bench for dnn_sample_feeder (p=64, zbyfo=4, nout=4, answ=1, ec=2).
module tb_dnn_sample_feeder;
  localparam int WI = 8, P = 64, Z = 4, NO = 4, AN = 1, EC = 2, EW = 4;

  logic                 clk = 1'b0;
  logic                 reset = 1'b1;
  logic [4:0]           ci = '0;
  logic                 ld_valid = 1'b0;
  logic                 ld_ready;
  logic [Z-1:0][WI-1:0] ld_act = '0;
  logic [NO-1:0]        ld_ans = '0;
  logic [EW-1:0]        ld_etapos = '0;
  logic [Z-1:0][WI-1:0] act0;
  logic [AN-1:0]        ans0;
  logic [EW-1:0]        etapos0;
  logic                 sample_valid;
  logic [15:0]          fed_count, underflow_count;

  int total = 0, bad = 0;
  int cur_s = 0, beat = 0, load_rem = 0, played = 0;
  bit stall = 1'b0;
  logic rdy_log [18];

  logic [3:0] ans_tab [9] = '{4'b0100, 4'b1011, 4'b0110, 4'b1001, 4'b0011,
                              4'b1100, 4'b0101, 4'b1110, 4'b0111};
  logic [3:0] eta_tab [9] = '{4'd5, 4'd3, 4'd9, 4'd12, 4'd7, 4'd15, 4'd2, 4'd11, 4'd6};

  dnn_sample_feeder #(.width_in(WI), .p(P), .zbyfo(Z), .nout(NO), .answ(AN),
                      .ec(EC), .etaw(EW)) dut (
    .clk(clk), .reset(reset), .cycle_index(ci),
    .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_act(ld_act),
    .ld_ans(ld_ans), .ld_etapos(ld_etapos),
    .act0(act0), .ans0(ans0), .etapos0(etapos0), .sample_valid(sample_valid),
    .fed_count(fed_count), .underflow_count(underflow_count)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  // sample s chunk k; sample 0 has every element equal to k
  function automatic logic [Z-1:0][WI-1:0] chunk(int s, int k);
    logic [Z-1:0][WI-1:0] c;
    for (int j = 0; j < Z; j++) c[j] = (s == 0) ? 8'(k) : 8'(s * 37 + k * 5 + j * 11 + 1);
    return c;
  endfunction

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // ans/etapos are only meaningful on the final beat; drive inverted junk elsewhere
  task automatic drive_loader();
    if (load_rem > 0 && (!stall || $urandom_range(0, 2) != 0)) begin
      ld_valid  = 1'b1;
      ld_act    = chunk(cur_s, beat);
      ld_ans    = (beat == 15) ? ans_tab[cur_s] : ~ans_tab[cur_s];
      ld_etapos = (beat == 15) ? eta_tab[cur_s] : ~eta_tab[cur_s];
    end else begin
      ld_valid  = 1'b0;
      ld_act    = '0;
      ld_ans    = '0;
      ld_etapos = '0;
    end
  endtask

  task automatic tick();
    logic acc;
    acc = ld_valid && ld_ready && !reset;
    @(posedge clk);
    #1;
    ci = (ci == 5'd17) ? 5'd0 : ci + 5'd1;
    if (acc) begin
      if (beat == 15) begin
        beat = 0;
        cur_s++;
        load_rem--;
      end else begin
        beat++;
      end
    end
    drive_loader();
  endtask

  task automatic wait_ci(logic [4:0] t);
    do tick(); while (ci != t);
  endtask

  task automatic start_load(int s, int n, bit st);
    cur_s = s; load_rem = n; beat = 0; stall = st;
    drive_loader();
  endtask

  // reset held until the counter wraps, so every test starts at cycle_index 0
  task automatic do_reset();
    reset = 1'b1;
    load_rem = 0; beat = 0; stall = 1'b0;
    drive_loader();
    tick();
    tick();
    while (ci != 5'd0) tick();
    reset = 1'b0;
  endtask

  // entered at cycle_index 0 of a playing block; leaves at 0 of the next one
  task automatic check_block(int s);
    for (int k = 0; k < 18; k++) begin
      chk($sformatf("act_s%0d_k%0d", s, k), 64'(act0), (k < 16) ? 64'(chunk(s, k)) : 64'd0);
      chk($sformatf("ans_s%0d_k%0d", s, k), 64'(ans0), (k < 4) ? 64'(ans_tab[s][k]) : 64'd0);
      chk($sformatf("eta_s%0d_k%0d", s, k), 64'(etapos0), 64'(eta_tab[s]));
      chk($sformatf("sv_s%0d_k%0d", s, k), 64'(sample_valid), 64'd1);
      rdy_log[k] = ld_ready;
      tick();
    end
  endtask

  initial begin
    // reset state
    do_reset();
    chk("rst_act", 64'(act0), 64'd0);
    chk("rst_ans", 64'(ans0), 64'd0);
    chk("rst_eta", 64'(etapos0), 64'd0);
    chk("rst_sv", 64'(sample_valid), 64'd0);
    chk("rst_fed", 64'(fed_count), 64'd0);
    chk("rst_und", 64'(underflow_count), 64'd0);
    chk("rst_rdy", 64'(ld_ready), 64'd1);

    // 1: idle loader for three block cycles
    for (int i = 0; i < 54; i++) begin
      tick();
      chk($sformatf("t1_sv_%0d", i), 64'(sample_valid), 64'd0);
      chk($sformatf("t1_act_%0d", i), 64'(act0), 64'd0);
      chk($sformatf("t1_eta_%0d", i), 64'(etapos0), 64'd0);
    end
    chk("t1_und", 64'(underflow_count), 64'd3);
    chk("t1_rdy", 64'(ld_ready), 64'd1);

    // 2: sample A loaded ahead of the boundary plays in the next block
    start_load(0, 1, 1'b0);
    wait_ci(5'd0);
    chk("t2_fed", 64'(fed_count), 64'd1);
    chk("t2_und", 64'(underflow_count), 64'd3);
    check_block(0);
    chk("t2_bub_sv", 64'(sample_valid), 64'd0);
    chk("t2_bub_eta", 64'(etapos0), 64'd0);
    chk("t2_bub_und", 64'(underflow_count), 64'd4);

    // 3: back-to-back samples, no bubble between them
    do_reset();
    start_load(1, 2, 1'b0);
    wait_ci(5'd0);
    chk("t3_fed1", 64'(fed_count), 64'd1);
    chk("t3_und1", 64'(underflow_count), 64'd0);
    check_block(1);
    chk("t3_rdy_k13", 64'(rdy_log[13]), 64'd1);
    chk("t3_rdy_k14", 64'(rdy_log[14]), 64'd0);
    chk("t3_rdy_k17", 64'(rdy_log[17]), 64'd0);
    chk("t3_rdy_rise", 64'(ld_ready), 64'd1);
    chk("t3_fed2", 64'(fed_count), 64'd2);
    chk("t3_und2", 64'(underflow_count), 64'd0);
    check_block(2);
    chk("t3_bub_sv", 64'(sample_valid), 64'd0);
    chk("t3_bub_und", 64'(underflow_count), 64'd1);
    chk("t3_bub_fed", 64'(fed_count), 64'd2);

    // 4: final beat lands on the boundary edge -> one bubble first
    do_reset();
    tick();
    tick();
    start_load(3, 1, 1'b0);
    wait_ci(5'd0);
    chk("t4_bub_sv", 64'(sample_valid), 64'd0);
    chk("t4_bub_act", 64'(act0), 64'd0);
    chk("t4_bub_und", 64'(underflow_count), 64'd1);
    chk("t4_bub_fed", 64'(fed_count), 64'd0);
    wait_ci(5'd0);
    chk("t4_fed", 64'(fed_count), 64'd1);
    chk("t4_und", 64'(underflow_count), 64'd1);
    check_block(3);

    // 5: reset mid-stream with the second bank half loaded
    do_reset();
    start_load(4, 2, 1'b0);
    wait_ci(5'd0);
    while (ci != 5'd7) tick();
    chk("t5_pre_sv", 64'(sample_valid), 64'd1);
    chk("t5_pre_act", 64'(act0), 64'(chunk(4, 7)));
    load_rem = 0;
    beat = 0;
    drive_loader();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("t5_act", 64'(act0), 64'd0);
    chk("t5_ans", 64'(ans0), 64'd0);
    chk("t5_eta", 64'(etapos0), 64'd0);
    chk("t5_sv", 64'(sample_valid), 64'd0);
    chk("t5_fed", 64'(fed_count), 64'd0);
    chk("t5_und", 64'(underflow_count), 64'd0);
    chk("t5_rdy", 64'(ld_ready), 64'd1);
    wait_ci(5'd0);
    chk("t5_empty_sv", 64'(sample_valid), 64'd0);
    chk("t5_empty_und", 64'(underflow_count), 64'd1);
    start_load(6, 1, 1'b0);
    wait_ci(5'd0);
    chk("t5_new_fed", 64'(fed_count), 64'd1);
    check_block(6);

    // 6: random loader stalls across two samples
    do_reset();
    start_load(7, 2, 1'b1);
    played = 0;
    for (int b = 0; b < 20 && played < 2; b++) begin
      if (sample_valid) begin
        check_block(7 + played);
        played++;
      end else begin
        wait_ci(5'd0);
      end
    end
    chk("t6_played", 64'(played), 64'd2);
    chk("t6_fed", 64'(fed_count), 64'd2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
